// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator with pixel strobe, sync/blank decode and gated RGB
// Optional build macro: VGA_TEST_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
// Ports:
//   clk, reset (sync, active-low), v_enable (low freezes the generator)
//   r_in/g_in/b_in       pixel source colour, presented one pixel ahead
//   R/G/B                gated colour, zero outside the visible area
//   horiz_sync/vert_sync sync pulses with HS_POL/VS_POL asserted level
//   pix_tick             one-clk pixel strobe every CLK_DIV enabled clks
//   display              visible-area flag
//   horiz_count/vert_count current pixel column / line
//   frame_start/line_end one-clk markers on reaching (0,0) / last column
//   pattern_sel          (VGA_TEST_PATTERN_EN only) selects the colour-bar pattern
module vga_timing_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int COLOR_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               v_enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               pattern_sel,
`endif
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               horiz_sync,
  output logic               vert_sync,
  output logic               pix_tick,
  output logic               display,
  output logic [CNT_W-1:0]   horiz_count,
  output logic [CNT_W-1:0]   vert_count,
  output logic               frame_start,
  output logic               line_end
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  logic [DW-1:0] div;
  logic tick, h_wrap, nd;
  logic [CNT_W-1:0] nh, nv;
  logic [COLOR_W-1:0] nr, ng, nb;
  // Everything registered on a tick is decoded from the post-tick counts so
  // that flags and colour always match the counts they are shown with.
  always_comb begin
    tick = v_enable && div == DIV_MAX;
    h_wrap = horiz_count == H_LAST;
    nh = h_wrap ? '0 : horiz_count + CNT_W'(1);
    nv = !h_wrap ? vert_count : vert_count == V_LAST ? '0 : vert_count + CNT_W'(1);
    nd = nh < H_ACT && nv < V_ACT;
  end
`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
  logic [CNT_W-1:0] bar;
  logic [2:0] bc;
  // Bars run white..black left to right: colour code is 7 minus the bar index.
  always_comb begin
    bar = nh / CNT_W'(BAR_W);
    bc = 3'd7 - (bar > CNT_W'(7) ? 3'd7 : bar[2:0]);
    nr = pattern_sel ? {COLOR_W{bc[2]}} : r_in;
    ng = pattern_sel ? {COLOR_W{bc[1]}} : g_in;
    nb = pattern_sel ? {COLOR_W{bc[0]}} : b_in;
  end
`else
  always_comb begin
    nr = r_in;
    ng = g_in;
    nb = b_in;
  end
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      div <= '0;
      pix_tick <= 1'b0;
      frame_start <= 1'b0;
      line_end <= 1'b0;
      horiz_count <= H_LAST;
      vert_count <= V_LAST;
      display <= 1'b0;
      horiz_sync <= ~HS_POL;
      vert_sync <= ~VS_POL;
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      pix_tick <= tick;
      frame_start <= tick && nh == '0 && nv == '0;
      line_end <= tick && nh == H_LAST;
      if (v_enable) div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        horiz_count <= nh;
        vert_count <= nv;
        display <= nd;
        horiz_sync <= (nh >= H_SS && nh < H_SE) ? HS_POL : ~HS_POL;
        vert_sync <= (nv >= V_SS && nv < V_SE) ? VS_POL : ~VS_POL;
        R <= nd ? nr : '0;
        G <= nd ? ng : '0;
        B <= nd ? nb : '0;
      end
    end
endmodule
